// File: rtl/alu_pkg.sv
// Shared opcode encodings, FSM state type and opcode classification helpers
// for the sequential ALU core and its iterative multiplier.
package alu_pkg;

   localparam logic [3:0] OP_ADD  = 4'd0;
   localparam logic [3:0] OP_SUB  = 4'd1;
   localparam logic [3:0] OP_AND  = 4'd2;
   localparam logic [3:0] OP_OR   = 4'd3;
   localparam logic [3:0] OP_XOR  = 4'd4;
   localparam logic [3:0] OP_NOT  = 4'd5;
   localparam logic [3:0] OP_SHL  = 4'd6;
   localparam logic [3:0] OP_SHR  = 4'd7;
   localparam logic [3:0] OP_SRA  = 4'd8;
   localparam logic [3:0] OP_ADC  = 4'd9;
   localparam logic [3:0] OP_MUL  = 4'd10;
   localparam logic [3:0] OP_MULH = 4'd11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   function automatic logic is_mul(input logic [3:0] op);
      return (op == OP_MUL) || (op == OP_MULH);
   endfunction

   // Ops whose carry output is remembered for a later ADC.
   function automatic logic sets_carry(input logic [3:0] op);
      case (op)
         OP_ADD, OP_SUB, OP_ADC, OP_SHL, OP_SHR, OP_SRA: return 1'b1;
         default:                                        return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// Unsigned shift-add multiplier: one partial product per cycle, WIDTH cycles
// per product; the start cycle already performs the first iteration.
module alu_mul_iter
   import alu_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] product
);

   localparam int SHW = $clog2(WIDTH);

   logic [WIDTH-1:0] hi, lo, mcand;
   logic [WIDTH-1:0] cur_hi, cur_lo, cur_mcand;
   logic [WIDTH:0]   sum;
   logic [SHW-1:0]   cnt;

   // On start the fresh operands feed the adder directly, saving a load cycle.
   always_comb begin
      cur_hi    = start ? '0 : hi;
      cur_lo    = start ? b  : lo;
      cur_mcand = start ? a  : mcand;
      sum       = {1'b0, cur_hi} + (cur_lo[0] ? {1'b0, cur_mcand} : '0);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         busy <= 1'b0;
         done <= 1'b0;
         cnt  <= '0;
      end else begin
         done <= 1'b0;
         if (start) begin
            busy <= 1'b1;
            cnt  <= SHW'(1);
         end else if (busy) begin
            cnt <= cnt + 1'b1;
            if (cnt == SHW'(WIDTH - 1)) begin
               busy <= 1'b0;
               done <= 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (start || busy) begin
         hi    <= sum[WIDTH:1];
         lo    <= {sum[0], cur_lo[WIDTH-1:1]};
         mcand <= cur_mcand;
      end
   end

   assign product = {hi, lo};

endmodule

// File: rtl/alu_seq_core.sv
// Registered WIDTH-bit ALU with valid/ready on both sides, C/Z/N/V flags,
// stored carry for ADC and an iterative multiplier for MUL/MULH.
module alu_seq_core
   import alu_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [3:0]       opcode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             carry,
   output logic             zero,
   output logic             neg,
   output logic             ovf,
   output logic             err
);

   localparam int SHW = $clog2(WIDTH);

   state_t               state;
   logic [3:0]           op_q;
   logic                 cflag;
   logic                 accept, mul_start, mul_busy, mul_done;
   logic [2*WIDTH-1:0]   product;
   logic [SHW-1:0]       amt;
   logic [WIDTH:0]       add_ext, sub_ext, shl_ext, shr_ext;
   logic signed [WIDTH:0] sra_ext;
   logic [WIDTH-1:0]     alu_res, mul_res;
   logic                 alu_c, alu_v, alu_e, mul_c;

   // in_ready is only ever high in IDLE, so it doubles as the state qualifier.
   assign accept    = in_valid & in_ready;
   assign mul_start = accept & is_mul(opcode);
   assign amt       = b[SHW-1:0];

   // Shifts carry one guard bit so the last bit shifted out lands in a fixed position.
   assign add_ext = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, (opcode == OP_ADC) & cflag};
   assign sub_ext = {1'b0, a} - {1'b0, b};
   assign shl_ext = {1'b0, a} << amt;
   assign shr_ext = {a, 1'b0} >> amt;
   assign sra_ext = $signed({a, 1'b0}) >>> amt;

   always_comb begin
      alu_res = '0;
      alu_c   = 1'b0;
      alu_v   = 1'b0;
      alu_e   = 1'b0;
      case (opcode)
         OP_ADD, OP_ADC: begin
            alu_res = add_ext[WIDTH-1:0];
            alu_c   = add_ext[WIDTH];
            alu_v   = (a[WIDTH-1] == b[WIDTH-1]) && (add_ext[WIDTH-1] != a[WIDTH-1]);
         end
         OP_SUB: begin
            alu_res = sub_ext[WIDTH-1:0];
            alu_c   = sub_ext[WIDTH];
            alu_v   = (a[WIDTH-1] != b[WIDTH-1]) && (sub_ext[WIDTH-1] != a[WIDTH-1]);
         end
         OP_AND: alu_res = a & b;
         OP_OR:  alu_res = a | b;
         OP_XOR: alu_res = a ^ b;
         OP_NOT: alu_res = ~a;
         OP_SHL: begin
            alu_res = shl_ext[WIDTH-1:0];
            alu_c   = shl_ext[WIDTH];
         end
         OP_SHR: begin
            alu_res = shr_ext[WIDTH:1];
            alu_c   = shr_ext[0];
         end
         OP_SRA: begin
            alu_res = sra_ext[WIDTH:1];
            alu_c   = sra_ext[0];
         end
         OP_MUL, OP_MULH: ;
         default: alu_e = 1'b1;
      endcase
   end

   assign mul_res = (op_q == OP_MULH) ? product[2*WIDTH-1:WIDTH] : product[WIDTH-1:0];
   assign mul_c   = (op_q == OP_MUL) & (|product[2*WIDTH-1:WIDTH]);

   alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (mul_start),
      .a       (a),
      .b       (b),
      .busy    (mul_busy),
      .done    (mul_done),
      .product (product)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         in_ready  <= 1'b0;
         out_valid <= 1'b0;
         op_q      <= '0;
         cflag     <= 1'b0;
         result    <= '0;
         carry     <= 1'b0;
         zero      <= 1'b0;
         neg       <= 1'b0;
         ovf       <= 1'b0;
         err       <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               in_ready <= 1'b1;
               if (accept) begin
                  in_ready <= 1'b0;
                  op_q     <= opcode;
                  if (is_mul(opcode)) begin
                     state <= ST_EXEC;
                  end else begin
                     state     <= ST_DONE;
                     out_valid <= 1'b1;
                     result    <= alu_res;
                     carry     <= alu_c;
                     zero      <= (alu_res == '0);
                     neg       <= alu_res[WIDTH-1];
                     ovf       <= alu_v;
                     err       <= alu_e;
                     if (sets_carry(opcode)) cflag <= alu_c;
                  end
               end
            end
            ST_EXEC: begin
               if (mul_done) begin
                  state     <= ST_DONE;
                  out_valid <= 1'b1;
                  result    <= mul_res;
                  carry     <= mul_c;
                  zero      <= (mul_res == '0);
                  neg       <= mul_res[WIDTH-1];
                  ovf       <= 1'b0;
                  err       <= 1'b0;
               end else if (!mul_busy) begin
                  // Multiplier idle without a result: recover rather than hang.
                  state    <= ST_IDLE;
                  in_ready <= 1'b1;
               end
            end
            ST_DONE: begin
               if (out_ready) begin
                  state     <= ST_IDLE;
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
               end
            end
            default: begin
               state    <= ST_IDLE;
               in_ready <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_seq_core.sv
// Bench for alu_seq_core (WIDTH=8): directed table, reset/throughput sequences
// and randomized ops against an arithmetic reference model.
module tb_alu_seq_core;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] a, b;
   logic [3:0] opcode;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] result;
   logic       carry, zero, neg, ovf, err;

   int total = 0;
   int bad   = 0;
   int mcarry = 0;

   always #5 clk = ~clk;

   alu_seq_core #(.WIDTH(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .opcode    (opcode),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .carry     (carry),
      .zero      (zero),
      .neg       (neg),
      .ovf       (ovf),
      .err       (err)
   );

   typedef struct {
      logic [3:0] op;
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] res;
      logic [4:0] flg;   // {carry, zero, neg, ovf, err}
      int         lat;
      int         hold;
   } vec_t;

   localparam int NV = 19;
   vec_t vecs [NV];

   task automatic check(input string nm, input int idx, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s[%0d] got=%0h expected=%0h", nm, idx, got, exp);
      end
   endtask

   // Reference: results and flags from plain integer arithmetic on the opcode rules.
   function automatic void model(input int ma, input int mb, input int mop,
                                 output int er, output int ef, output int el);
      int sa, sb, s, n, p, c, v, e;
      sa = (ma > 127) ? ma - 256 : ma;
      sb = (mb > 127) ? mb - 256 : mb;
      n  = mb % 8;
      c = 0; v = 0; e = 0; er = 0; el = 1;
      p = ma * mb;
      case (mop)
         0: begin s = ma + mb; er = s % 256; c = (s > 255); s = sa + sb;
                  v = (s > 127) || (s < -128); mcarry = c; end
         1: begin er = (ma - mb + 256) % 256; c = (ma < mb); s = sa - sb;
                  v = (s > 127) || (s < -128); mcarry = c; end
         2: er = ma & mb;
         3: er = ma | mb;
         4: er = ma ^ mb;
         5: er = 255 - ma;
         6: begin er = (ma << n) % 256; c = (n != 0) ? ((ma >> (8 - n)) & 1) : 0; mcarry = c; end
         7: begin er = ma >> n; c = (n != 0) ? ((ma >> (n - 1)) & 1) : 0; mcarry = c; end
         8: begin er = (sa >>> n) & 255; c = (n != 0) ? ((ma >> (n - 1)) & 1) : 0; mcarry = c; end
         9: begin s = ma + mb + mcarry; er = s % 256; c = (s > 255); s = sa + sb + mcarry;
                  v = (s > 127) || (s < -128); mcarry = c; end
         10: begin er = p % 256; c = ((p / 256) != 0); el = 9; end
         11: begin er = p / 256; el = 9; end
         default: e = 1;
      endcase
      ef = c * 16 + ((er == 0) ? 8 : 0) + ((er > 127) ? 4 : 0) + v * 2 + e;
   endfunction

   task automatic run_op(input logic [7:0] ta, input logic [7:0] tb2, input logic [3:0] top,
                         input int hold, output logic [7:0] r, output logic [4:0] f, output int lat);
      int w;
      @(negedge clk);
      w = 0;
      while (!in_ready && w < 50) begin
         @(negedge clk);
         w++;
      end
      if (!in_ready) begin
         total++;
         bad++;
         $display("FAIL accept_wait in_ready=0 expected=1");
      end
      a = ta; b = tb2; opcode = top; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      a = 8'($urandom); b = 8'($urandom); opcode = 4'($urandom);
      lat = 1;
      while (!out_valid && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      r = result;
      f = {carry, zero, neg, ovf, err};
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         check("hold_stable", i, 32'({out_valid, in_ready, result, carry, zero, neg, ovf, err}),
               32'({1'b1, 1'b0, r, f}));
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   initial begin
      logic [7:0] r;
      logic [4:0] f;
      int lat, er, ef, el, w, acc, clash, seen;

      vecs[0]  = '{4'd0,  8'hFF, 8'h01, 8'h00, 5'b11000, 1, 1};
      vecs[1]  = '{4'd9,  8'h10, 8'h20, 8'h31, 5'b00000, 1, 1};
      vecs[2]  = '{4'd1,  8'h03, 8'h05, 8'hFE, 5'b10100, 1, 1};
      vecs[3]  = '{4'd1,  8'h80, 8'h01, 8'h7F, 5'b00010, 1, 1};
      vecs[4]  = '{4'd8,  8'h80, 8'h03, 8'hF0, 5'b00100, 1, 1};
      vecs[5]  = '{4'd6,  8'h81, 8'h01, 8'h02, 5'b10000, 1, 1};
      vecs[6]  = '{4'd7,  8'h05, 8'h00, 8'h05, 5'b00000, 1, 1};
      vecs[7]  = '{4'd10, 8'h0F, 8'h11, 8'hFF, 5'b00100, 9, 1};
      vecs[8]  = '{4'd11, 8'h0F, 8'h11, 8'h00, 5'b01000, 9, 1};
      vecs[9]  = '{4'd10, 8'hFF, 8'hFF, 8'h01, 5'b10000, 9, 3};
      vecs[10] = '{4'd12, 8'h12, 8'h34, 8'h00, 5'b01001, 1, 1};
      vecs[11] = '{4'd2,  8'hF0, 8'h3C, 8'h30, 5'b00000, 1, 1};
      vecs[12] = '{4'd4,  8'hFF, 8'h0F, 8'hF0, 5'b00100, 1, 1};
      vecs[13] = '{4'd5,  8'h5A, 8'h00, 8'hA5, 5'b00100, 1, 1};
      vecs[14] = '{4'd3,  8'h00, 8'h00, 8'h00, 5'b01000, 1, 1};
      vecs[15] = '{4'd1,  8'h00, 8'h01, 8'hFF, 5'b10100, 1, 1};
      vecs[16] = '{4'd15, 8'hAA, 8'h55, 8'h00, 5'b01001, 1, 1};
      vecs[17] = '{4'd2,  8'hFF, 8'hFF, 8'hFF, 5'b00100, 1, 1};
      vecs[18] = '{4'd9,  8'h7F, 8'h00, 8'h80, 5'b00110, 1, 1};

      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      a = '0; b = '0; opcode = '0;
      repeat (3) @(negedge clk);
      check("reset_outputs", 0, 32'({out_valid, in_ready, result, carry, zero, neg, ovf, err}), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      check("ready_after_reset", 0, 32'(in_ready), 32'd1);

      for (int i = 0; i < NV; i++) begin
         model(int'(vecs[i].a), int'(vecs[i].b), int'(vecs[i].op), er, ef, el);
         run_op(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].hold, r, f, lat);
         check("vec_result", i, 32'(r), 32'(vecs[i].res));
         check("vec_flags", i, 32'(f), 32'(vecs[i].flg));
         check("vec_latency", i, 32'(lat), 32'(vecs[i].lat));
      end

      // Reset four cycles into a multiply: the op must vanish without an out_valid pulse.
      @(negedge clk);
      w = 0;
      while (!in_ready && w < 50) begin
         @(negedge clk);
         w++;
      end
      a = 8'h0F; b = 8'h11; opcode = 4'd10; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check("midmul_reset_valid", 0, 32'(out_valid), 32'd0);
      @(negedge clk);
      check("midmul_ready", 0, 32'(in_ready), 32'd1);
      mcarry = 0;
      seen = 0;
      for (int i = 0; i < 12; i++) begin
         if (out_valid) seen++;
         @(negedge clk);
      end
      check("midmul_no_pulse", 0, 32'(seen), 32'd0);
      model(1, 1, 9, er, ef, el);
      run_op(8'h01, 8'h01, 4'd9, 0, r, f, lat);
      check("adc_after_reset_res", 0, 32'(r), 32'h02);
      check("adc_after_reset_flags", 0, 32'(f), 32'd0);

      // Continuous in_valid with out_ready high: an accept every second cycle.
      @(negedge clk);
      opcode = 4'd2; a = 8'h3C; b = 8'hC3; in_valid = 1'b1; out_ready = 1'b1;
      acc = 0; clash = 0;
      for (int i = 0; i < 10; i++) begin
         if (in_ready) acc++;
         if (in_ready && out_valid) clash++;
         @(negedge clk);
      end
      in_valid = 1'b0;
      @(negedge clk);
      out_ready = 1'b0;
      check("b2b_accepts", 0, 32'(acc), 32'd5);
      check("b2b_ready_vs_valid", 0, 32'(clash), 32'd0);

      for (int i = 0; i < 150; i++) begin
         logic [7:0] ra, rb;
         logic [3:0] rop;
         int hold;
         ra = 8'($urandom_range(0, 255));
         rb = 8'($urandom_range(0, 255));
         rop = 4'($urandom_range(0, 15));
         hold = $urandom_range(0, 2);
         model(int'(ra), int'(rb), int'(rop), er, ef, el);
         run_op(ra, rb, rop, hold, r, f, lat);
         check("rnd_result", i, 32'(r), 32'(er));
         check("rnd_flags", i, 32'(f), 32'(ef));
         check("rnd_latency", i, 32'(lat), 32'(el));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
